soc_system_sram_msg_queue: RTL and testbench

//  Word-wide message FIFO whose storage is a window of the on-chip SRAM. Sits directly upstream of
//  the SRAM and drives its single-port, Avalon-style slave interface as the sole master.

---
 rtl/soc_system_sram_msg_queue_if.sv | 31 +++
 rtl/soc_system_sram_msg_queue.sv | 235 +++++++++++++++++++++++
 tb/tb_soc_system_sram_msg_queue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_sram_msg_queue_if.sv
// ---------------------------------------------------------------------------
// soc_system_sram_msg_queue_if
// Producer/consumer handshake bundle for the SRAM-backed message queue.
//   push_valid/push_ready/push_data : producer side, word accepted on valid & ready
//   pop_valid/pop_ready/pop_data    : consumer side, word taken on valid & ready
//   level                           : words currently held by the queue
// Modports:
//   slave  - the queue itself (accepts pushes, serves pops)
//   master - the client driving pushes and pops
// ---------------------------------------------------------------------------
interface soc_system_sram_msg_queue_if #(
  parameter int unsigned DEPTH_LOG2 = 10
);
  logic                  push_valid;
  logic                  push_ready;
  logic [31:0]           push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [31:0]           pop_data;
  logic [DEPTH_LOG2:0]   level;

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, level
  );

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, level
  );
endinterface

// File: rtl/soc_system_sram_msg_queue.sv
// ---------------------------------------------------------------------------
// soc_system_sram_msg_queue
// Word-wide message FIFO whose ring storage lives in a window of the on-chip
// SRAM. The queue is the only master of the SRAM's single-port slave interface
// and performs at most one access per cycle. The head word is prefetched into
// a registered output so the consumer sees it without SRAM latency.
//
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   flush             synchronous clear, discards all held words
//   q_if (slave)      push/pop handshake and level
//   sram_*            Avalon-style SRAM master signals; readdata returns the
//                     cycle after a read is issued
//   hwm_clr, hwm      high-water mark of level (only with SRAM_MSGQ_HWM_EN)
//
// Optional feature macro: SRAM_MSGQ_HWM_EN adds the high-water mark ports.
// ---------------------------------------------------------------------------
module soc_system_sram_msg_queue #(
  parameter logic [16:0] BASE_ADDR  = 17'h00000,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  soc_system_sram_msg_queue_if.slave q_if,
  output logic [16:0]                sram_address,
  output logic [3:0]                 sram_byteenable,
  output logic                       sram_chipselect,
  output logic                       sram_write,
  output logic [31:0]                sram_writedata,
  output logic                       sram_clken,
  input  logic [31:0]                sram_readdata
`ifdef SRAM_MSGQ_HWM_EN
  ,
  input  logic                       hwm_clr,
  output logic [DEPTH_LOG2:0]        hwm
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  localparam logic [DEPTH_LOG2:0] PTR_ZERO    = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0] PTR_ONE     = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DEPTH_LOG2:0] wr_ptr_r;
  logic [DEPTH_LOG2:0] rd_ptr_r;
  logic [DEPTH_LOG2:0] sram_cnt_s;
  logic [DEPTH_LOG2:0] level_r;
  logic [DEPTH_LOG2:0] level_nxt_s;
  logic                full_s;
  logic                empty_s;
  logic                rd_go_s;
  logic                wr_go_s;
  logic                push_ready_s;
  logic                pop_fire_s;
  logic                pop_valid_r;
  logic [31:0]         pop_data_r;
  state_t              state_r;
  state_t              state_nxt_s;

  // Map a ring pointer to its SRAM word address (wrap bit dropped).
  function automatic logic [16:0] ring_addr(input logic [DEPTH_LOG2:0] ptr);
    ring_addr = BASE_ADDR + {{(17-DEPTH_LOG2){1'b0}}, ptr[DEPTH_LOG2-1:0]};
  endfunction

  // Occupancy, handshake and access scheduling; reads take priority over writes.
  always_comb begin
    sram_cnt_s   = wr_ptr_r - rd_ptr_r;
    full_s       = (sram_cnt_s == DEPTH_WORDS);
    empty_s      = (sram_cnt_s == PTR_ZERO);
    pop_fire_s   = pop_valid_r & q_if.pop_ready;
    // Refill the prefetch register when it is empty or being emptied this cycle.
    rd_go_s      = (state_r == ST_IDLE) & ~empty_s &
                   (~pop_valid_r | q_if.pop_ready) & ~flush;
    // Independent of push_valid so the producer sees no combinational loop.
    push_ready_s = ~full_s & ~flush & ~rd_go_s;
    wr_go_s      = q_if.push_valid & push_ready_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else if (flush) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: a read always spends exactly one cycle in RD_WAIT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_go_s) begin
          state_nxt_s = ST_RD_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: SRAM strobes for the single access of this cycle.
  always_comb begin
    sram_chipselect = 1'b0;
    sram_write      = 1'b0;
    sram_address    = ring_addr(wr_ptr_r);
    case (state_r)
      ST_IDLE: begin
        if (rd_go_s) begin
          sram_chipselect = 1'b1;
          sram_write      = 1'b0;
          sram_address    = ring_addr(rd_ptr_r);
        end else if (wr_go_s) begin
          sram_chipselect = 1'b1;
          sram_write      = 1'b1;
          sram_address    = ring_addr(wr_ptr_r);
        end else begin
          sram_chipselect = 1'b0;
          sram_write      = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        // The SRAM port is free while read data returns, so a push may proceed.
        if (wr_go_s) begin
          sram_chipselect = 1'b1;
          sram_write      = 1'b1;
          sram_address    = ring_addr(wr_ptr_r);
        end else begin
          sram_chipselect = 1'b0;
          sram_write      = 1'b0;
        end
      end
      default: begin
        sram_chipselect = 1'b0;
        sram_write      = 1'b0;
      end
    endcase
  end

  assign sram_byteenable = 4'hF;
  assign sram_clken      = 1'b1;
  assign sram_writedata  = q_if.push_data;

  // Ring pointers; a flush returns both to the ring start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (rd_go_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (wr_go_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  // Prefetch register: captures returning read data, cleared when consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_valid_r <= 1'b0;
      pop_data_r  <= 32'h0000_0000;
    end else if (flush) begin
      // Any read still in flight is dropped here.
      pop_valid_r <= 1'b0;
    end else if (state_r == ST_RD_WAIT) begin
      // Prefetch is always empty in RD_WAIT, so no unconsumed word is lost.
      pop_valid_r <= 1'b1;
      pop_data_r  <= sram_readdata;
    end else if (pop_fire_s) begin
      pop_valid_r <= 1'b0;
    end
  end

  // Next level: a read only moves a word from SRAM to the prefetch path,
  // so only accepted pushes and consumed pops change the total.
  always_comb begin
    if (flush) begin
      level_nxt_s = PTR_ZERO;
    end else begin
      level_nxt_s = level_r + {{DEPTH_LOG2{1'b0}}, wr_go_s}
                            - {{DEPTH_LOG2{1'b0}}, pop_fire_s};
    end
  end

  // Registered word count (SRAM + in-flight read + prefetch register).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_r <= PTR_ZERO;
    end else begin
      level_r <= level_nxt_s;
    end
  end

  assign q_if.push_ready = push_ready_s;
  assign q_if.pop_valid  = pop_valid_r;
  assign q_if.pop_data   = pop_data_r;
  assign q_if.level      = level_r;

`ifdef SRAM_MSGQ_HWM_EN
  logic [DEPTH_LOG2:0] hwm_r;

  // High-water mark tracks the next level so it stays aligned with level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hwm_r <= PTR_ZERO;
    end else if (flush || hwm_clr) begin
      hwm_r <= PTR_ZERO;
    end else if (level_nxt_s > hwm_r) begin
      hwm_r <= level_nxt_s;
    end
  end

  assign hwm = hwm_r;
`endif

endmodule

// File: tb/tb_soc_system_sram_msg_queue.sv
// ---------------------------------------------------------------------------
// tb_soc_system_sram_msg_queue
// Directed bench for the SRAM-backed message queue with an 8-word ring placed
// at word address 0x10 of a behavioural SRAM. Inputs change 1 time unit after
// the rising edge; outputs are sampled mid-cycle.
// Define SRAM_MSGQ_HWM_EN to also exercise the high-water mark ports.
// ---------------------------------------------------------------------------
module tb_soc_system_sram_msg_queue;
  localparam int unsigned DL   = 3;
  localparam logic [16:0] BASE = 17'h00010;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [16:0] sram_address;
  logic [3:0]  sram_byteenable;
  logic        sram_chipselect;
  logic        sram_write;
  logic [31:0] sram_writedata;
  logic        sram_clken;
  logic [31:0] sram_readdata;
`ifdef SRAM_MSGQ_HWM_EN
  logic        hwm_clr;
  logic [DL:0] hwm;
`endif

  int checks = 0;
  int errors = 0;
  int m_wr_idx = 0;
  int m_rd_idx = 0;
  logic [31:0] mem [0:127];

  always #5 clk = ~clk;

  soc_system_sram_msg_queue_if #(.DEPTH_LOG2(DL)) q_if ();

  soc_system_sram_msg_queue #(
    .BASE_ADDR  (BASE),
    .DEPTH_LOG2 (DL)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush           (flush),
    .q_if            (q_if),
    .sram_address    (sram_address),
    .sram_byteenable (sram_byteenable),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_writedata  (sram_writedata),
    .sram_clken      (sram_clken),
    .sram_readdata   (sram_readdata)
`ifdef SRAM_MSGQ_HWM_EN
    ,
    .hwm_clr         (hwm_clr),
    .hwm             (hwm)
`endif
  );

  // Behavioural single-port SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (sram_chipselect === 1'b1) begin
      if (sram_write === 1'b1) mem[sram_address[6:0]] <= sram_writedata;
      else sram_readdata <= mem[sram_address[6:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus monitor: expected ring addresses come from independent write/read counters.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (flush === 1'b1) begin
        check("no_access_in_flush", {31'd0, sram_chipselect}, 32'd0);
        m_wr_idx = 0;
        m_rd_idx = 0;
      end else if (sram_chipselect === 1'b1) begin
        if (sram_write === 1'b1) begin
          check("wr_addr", {15'd0, sram_address}, 32'(BASE) + 32'(m_wr_idx % 8));
          check("wr_data", sram_writedata, q_if.push_data);
          m_wr_idx++;
        end else begin
          check("rd_addr", {15'd0, sram_address}, 32'(BASE) + 32'(m_rd_idx % 8));
          m_rd_idx++;
        end
      end
    end
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input string tag);
    bit done = 1'b0;
    q_if.push_valid = 1'b1;
    q_if.push_data  = d;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (q_if.push_ready === 1'b1) done = 1'b1;
      tick();
    end
    q_if.push_valid = 1'b0;
    check({tag, "_accept"}, {31'd0, done}, 32'd1);
  endtask

  task automatic pop_word(input logic [31:0] exp, input string tag);
    bit got = 1'b0;
    q_if.pop_ready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (q_if.pop_valid === 1'b1) begin
        got = 1'b1;
        check(tag, q_if.pop_data, exp);
      end
      tick();
    end
    q_if.pop_ready = 1'b0;
    check({tag, "_seen"}, {31'd0, got}, 32'd1);
  endtask

  // Concurrent push/pop traffic against an in-order scoreboard and level model.
  task automatic traffic(input int n_words, input bit rnd, input logic [31:0] base_val, input string tag);
    int pushed  = 0;
    int popped  = 0;
    int m_level = 0;
    int cyc     = 0;
    while ((pushed < n_words || popped < n_words) && cyc < 20 * n_words + 100) begin
      q_if.push_valid = (pushed < n_words) && (!rnd || $urandom_range(1, 0) == 1);
      q_if.push_data  = base_val + 32'(pushed);
      q_if.pop_ready  = !rnd || ($urandom_range(1, 0) == 1);
      #1;
      check({tag, "_level"}, 32'(q_if.level), 32'(m_level));
      if (q_if.pop_valid === 1'b1 && q_if.pop_ready === 1'b1) begin
        check({tag, "_data"}, q_if.pop_data, base_val + 32'(popped));
        popped++;
        m_level--;
      end
      if (q_if.push_valid === 1'b1 && q_if.push_ready === 1'b1) begin
        pushed++;
        m_level++;
      end
      tick();
      cyc++;
    end
    q_if.push_valid = 1'b0;
    q_if.pop_ready  = 1'b0;
    check({tag, "_pushed"}, 32'(pushed), 32'(n_words));
    check({tag, "_popped"}, 32'(popped), 32'(n_words));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    flush           = 1'b0;
    q_if.push_valid = 1'b0;
    q_if.push_data  = 32'd0;
    q_if.pop_ready  = 1'b0;
`ifdef SRAM_MSGQ_HWM_EN
    hwm_clr         = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_pop_valid", {31'd0, q_if.pop_valid}, 32'd0);
    check("rst_pop_data", q_if.pop_data, 32'd0);
    check("rst_level", 32'(q_if.level), 32'd0);
    check("rst_cs", {31'd0, sram_chipselect}, 32'd0);
    check("rst_write", {31'd0, sram_write}, 32'd0);
    check("byteenable", {28'd0, sram_byteenable}, 32'hF);
    check("clken", {31'd0, sram_clken}, 32'd1);
`ifdef SRAM_MSGQ_HWM_EN
    check("rst_hwm", 32'(hwm), 32'd0);
`endif
    reset_n = 1'b1;

    // Single word latency: write cycle 0, read cycle 1, valid cycle 3.
    q_if.push_valid = 1'b1;
    q_if.push_data  = 32'hDEADBEEF;
    #1;
    check("t1_c0_ready", {31'd0, q_if.push_ready}, 32'd1);
    check("t1_c0_cs", {31'd0, sram_chipselect}, 32'd1);
    check("t1_c0_wr", {31'd0, sram_write}, 32'd1);
    check("t1_c0_addr", {15'd0, sram_address}, 32'h10);
    tick();
    q_if.push_valid = 1'b0;
    #1;
    check("t1_c1_cs", {31'd0, sram_chipselect}, 32'd1);
    check("t1_c1_rd", {31'd0, sram_write}, 32'd0);
    check("t1_c1_addr", {15'd0, sram_address}, 32'h10);
    check("t1_c1_ready", {31'd0, q_if.push_ready}, 32'd0);
    check("t1_c1_level", 32'(q_if.level), 32'd1);
    tick();
    #1;
    check("t1_c2_valid", {31'd0, q_if.pop_valid}, 32'd0);
    tick();
    #1;
    check("t1_c3_valid", {31'd0, q_if.pop_valid}, 32'd1);
    check("t1_c3_data", q_if.pop_data, 32'hDEADBEEF);
    check("t1_c3_level", 32'(q_if.level), 32'd1);
    pop_word(32'hDEADBEEF, "t1_pop");
    #1;
    check("t1_end_level", 32'(q_if.level), 32'd0);
    check("t1_end_valid", {31'd0, q_if.pop_valid}, 32'd0);

    // Fill to 8 SRAM words + 1 prefetch, reject the 10th, then drain in order.
    for (int i = 1; i <= 9; i++) push_word(32'(i), "t2_push");
    repeat (3) tick();
    check("t2_level_full", 32'(q_if.level), 32'd9);
    check("t2_head", q_if.pop_data, 32'd1);
    q_if.push_valid = 1'b1;
    q_if.push_data  = 32'd10;
    #1;
    check("t2_full_ready", {31'd0, q_if.push_ready}, 32'd0);
    tick();
    q_if.push_valid = 1'b0;
    check("t2_full_level", 32'(q_if.level), 32'd9);
    for (int i = 1; i <= 9; i++) pop_word(32'(i), "t2_pop");
    repeat (2) tick();
    check("t2_empty_level", 32'(q_if.level), 32'd0);
    check("t2_empty_valid", {31'd0, q_if.pop_valid}, 32'd0);

    // Continuous streaming across several pointer wraps, then random traffic.
    traffic(20, 1'b0, 32'h0000_0100, "t3");
    traffic(300, 1'b1, 32'h0000_1000, "t4");

    // Flush while a read is in flight with 5 words held.
    for (int i = 0; i < 6; i++) push_word(32'h50 + 32'(i), "t5_push");
    repeat (3) tick();
    check("t5_level6", 32'(q_if.level), 32'd6);
    q_if.pop_ready = 1'b1;
    #1;
    check("t5_head", q_if.pop_data, 32'h50);
    tick();
    q_if.pop_ready = 1'b0;
    flush = 1'b1;
    #1;
    check("t5_level5", 32'(q_if.level), 32'd5);
    tick();
    flush = 1'b0;
    check("t5_flush_level", 32'(q_if.level), 32'd0);
    check("t5_flush_valid", {31'd0, q_if.pop_valid}, 32'd0);
    repeat (2) tick();
    check("t5_stay_valid", {31'd0, q_if.pop_valid}, 32'd0);
    check("t5_stay_level", 32'(q_if.level), 32'd0);
    push_word(32'h1, "t5_repush");
    pop_word(32'h1, "t5_repop");
    check("t5_end_level", 32'(q_if.level), 32'd0);

`ifdef SRAM_MSGQ_HWM_EN
    // High-water mark follows the peak level and clears on request.
    hwm_clr = 1'b1;
    tick();
    hwm_clr = 1'b0;
    check("t6_clr0", 32'(hwm), 32'd0);
    for (int i = 0; i < 6; i++) push_word(32'h60 + 32'(i), "t6_push");
    repeat (3) tick();
    check("t6_hwm_fill", 32'(hwm), 32'd6);
    for (int i = 0; i < 6; i++) pop_word(32'h60 + 32'(i), "t6_pop");
    tick();
    check("t6_level0", 32'(q_if.level), 32'd0);
    check("t6_hwm_drain", 32'(hwm), 32'd6);
    hwm_clr = 1'b1;
    tick();
    hwm_clr = 1'b0;
    check("t6_hwm_clr", 32'(hwm), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
